// File: rtl/ife_pkg.sv
// Shared types and default widths for the fallback path into the bypass stage.
package ife_pkg;

  localparam int IFE_BLOCK_ID_WIDTH = 8;
  localparam int IFE_INSTR_WIDTH    = 32;
  localparam int IFE_BLOCK_SIZE     = 4;
  localparam int IFE_CNT_WIDTH      = 16;
  localparam int IFE_BLOCK_WIDTH    = IFE_INSTR_WIDTH * IFE_BLOCK_SIZE;

  typedef logic [IFE_BLOCK_ID_WIDTH-1:0] ife_block_id_t;
  typedef logic [IFE_BLOCK_WIDTH-1:0]    ife_block_t;

  typedef enum logic {
    SRC_DISPATCH = 1'b0,
    SRC_COMMIT   = 1'b1
  } ife_src_e;

  // Round-robin helper: the source that did not win last time goes next.
  function automatic ife_src_e ife_other_src(input ife_src_e src);
    return (src == SRC_DISPATCH) ? SRC_COMMIT : SRC_DISPATCH;
  endfunction

endpackage

// File: rtl/ife_req_slot.sv
// One-entry request holding register: a full flag plus the captured id/payload.
module ife_req_slot
  import ife_pkg::*;
#(
  parameter int ID_WIDTH   = IFE_BLOCK_ID_WIDTH,
  parameter int DATA_WIDTH = IFE_BLOCK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [ID_WIDTH-1:0]   id_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic [ID_WIDTH-1:0]   id,
  output logic [DATA_WIDTH-1:0] data
);

  // Load wins over clear so a granted slot can refill on the same edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload is not reset; it is only ever consumed while full is set.
  always_ff @(posedge clk) begin
    if (load) begin
      id   <= id_in;
      data <= data_in;
    end
  end

endmodule

// File: rtl/ife_fallback_arbiter.sv
// Serialises dispatch/commit fallback requests onto the bypass fallback input,
// merging same-block requests and counting issued fallbacks.
module ife_fallback_arbiter
  import ife_pkg::*;
#(
  parameter int BLOCK_ID_WIDTH = IFE_BLOCK_ID_WIDTH,
  parameter int INSTR_WIDTH    = IFE_INSTR_WIDTH,
  parameter int BLOCK_SIZE     = IFE_BLOCK_SIZE,
  parameter int CNT_WIDTH      = IFE_CNT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              disp_valid,
  output logic                              disp_ready,
  input  logic [BLOCK_ID_WIDTH-1:0]         disp_block_id,
  input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] disp_block,
  input  logic                              cmt_valid,
  output logic                              cmt_ready,
  input  logic [BLOCK_ID_WIDTH-1:0]         cmt_block_id,
  input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] cmt_block,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BLOCK_ID_WIDTH-1:0]         block_id_out,
  output logic [BLOCK_SIZE*INSTR_WIDTH-1:0] block_out,
  output logic                              from_dispatch,
  output logic                              from_commit,
  output logic [CNT_WIDTH-1:0]              fallback_count
);

  localparam int BLOCK_WIDTH = BLOCK_SIZE * INSTR_WIDTH;

  logic                      d_full, c_full;
  logic [BLOCK_ID_WIDTH-1:0] d_id, c_id;
  logic [BLOCK_WIDTH-1:0]    d_block, c_block;

  logic     load, both_full, same_id, two_way;
  logic     grant_d, grant_c, issue;
  ife_src_e last_grant, rr_winner;

  ife_req_slot #(.ID_WIDTH(BLOCK_ID_WIDTH), .DATA_WIDTH(BLOCK_WIDTH)) u_disp_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (disp_valid && disp_ready),
    .clear   (grant_d),
    .id_in   (disp_block_id),
    .data_in (disp_block),
    .full    (d_full),
    .id      (d_id),
    .data    (d_block)
  );

  ife_req_slot #(.ID_WIDTH(BLOCK_ID_WIDTH), .DATA_WIDTH(BLOCK_WIDTH)) u_cmt_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (cmt_valid && cmt_ready),
    .clear   (grant_c),
    .id_in   (cmt_block_id),
    .data_in (cmt_block),
    .full    (c_full),
    .id      (c_id),
    .data    (c_block)
  );

  // Equal ids with both slots full grant both sources at once: that is the merge.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    load      = !out_valid || out_ready;
    both_full = d_full && c_full;
    same_id   = (d_id == c_id);
    rr_winner = ife_other_src(last_grant);
    grant_d   = 1'b0;
    grant_c   = 1'b0;
    if (load) begin
      if (both_full && same_id) begin
        grant_d = 1'b1;
        grant_c = 1'b1;
      end else if (both_full) begin
        grant_d = (rr_winner == SRC_DISPATCH);
        grant_c = (rr_winner == SRC_COMMIT);
      end else begin
        grant_d = d_full;
        grant_c = c_full;
      end
    end
    issue   = grant_d || grant_c;
    two_way = issue && both_full && !same_id;
  end

  assign disp_ready = !d_full || grant_d;
  assign cmt_ready  = !c_full || grant_c;

  // Commit payload is chosen whenever commit is granted, which covers the merge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      block_id_out  <= '0;
      block_out     <= '0;
      from_dispatch <= 1'b0;
      from_commit   <= 1'b0;
    end else if (load) begin
      out_valid <= issue;
      if (issue) begin
        block_id_out  <= grant_c ? c_id : d_id;
        block_out     <= grant_c ? c_block : d_block;
        from_dispatch <= grant_d;
        from_commit   <= grant_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= SRC_DISPATCH;
    end else if (two_way) begin
      last_grant <= grant_c ? SRC_COMMIT : SRC_DISPATCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fallback_count <= '0;
    end else if (out_valid && out_ready && (fallback_count != '1)) begin
      fallback_count <= fallback_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ife_fallback_arbiter.sv
// Directed bench for ife_fallback_arbiter: a per-cycle reference model plus literal checks.
module tb_ife_fallback_arbiter;

  localparam int IDW     = 8;
  localparam int IW      = 32;
  localparam int BS      = 4;
  localparam int CW      = 4;
  localparam int BW      = IW * BS;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk, rst;
  logic          disp_valid, disp_ready, cmt_valid, cmt_ready;
  logic [IDW-1:0] disp_block_id, cmt_block_id, block_id_out;
  logic [BW-1:0]  disp_block, cmt_block, block_out;
  logic          out_valid, out_ready, from_dispatch, from_commit;
  logic [CW-1:0] fallback_count;

  ife_fallback_arbiter #(
    .BLOCK_ID_WIDTH(IDW), .INSTR_WIDTH(IW), .BLOCK_SIZE(BS), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_block_id(disp_block_id), .disp_block(disp_block),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready),
    .cmt_block_id(cmt_block_id), .cmt_block(cmt_block),
    .out_valid(out_valid), .out_ready(out_ready),
    .block_id_out(block_id_out), .block_out(block_out),
    .from_dispatch(from_dispatch), .from_commit(from_commit),
    .fallback_count(fallback_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pay(input logic [IDW-1:0] id, input bit commit);
    logic [23:0] tag;
    tag = commit ? 24'hC0FFEE : 24'hD15BA7;
    return {4{tag, id}};
  endfunction

  // ---------------- reference model: index 0 = dispatch, 1 = commit ----------------
  typedef struct {
    bit             full;
    logic [IDW-1:0] id;
    logic [BW-1:0]  blk;
  } req_t;

  req_t           ms[2];
  bit             mo_valid, mo_fd, mo_fc;
  logic [IDW-1:0] mo_id;
  logic [BW-1:0]  mo_blk;
  int             m_cnt;
  int             m_last;  // source that won the most recent two-way contest

  function automatic void m_grants(output bit gd, output bit gc);
    gd = 0;
    gc = 0;
    if (mo_valid && !out_ready) return;
    if (ms[0].full && ms[1].full) begin
      if (ms[0].id == ms[1].id) begin
        gd = 1;
        gc = 1;
      end else if (m_last == 0) gc = 1;
      else gd = 1;
    end else begin
      gd = ms[0].full;
      gc = ms[1].full;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    bit gd, gc, acc_d, acc_c, contest;
    if (!rst) begin
      ms[0].full = 0;
      ms[1].full = 0;
      mo_valid = 0; mo_fd = 0; mo_fc = 0; mo_id = '0; mo_blk = '0;
      m_cnt = 0;
      m_last = 0;
    end else begin
      m_grants(gd, gc);
      acc_d   = disp_valid && (!ms[0].full || gd);
      acc_c   = cmt_valid && (!ms[1].full || gc);
      contest = ms[0].full && ms[1].full && !(gd && gc);
      if (mo_valid && out_ready && m_cnt < CNT_MAX) m_cnt++;
      if (!mo_valid || out_ready) begin
        mo_valid = gd || gc;
        if (gd || gc) begin
          mo_id  = gc ? ms[1].id : ms[0].id;
          mo_blk = gc ? ms[1].blk : ms[0].blk;
          mo_fd  = gd;
          mo_fc  = gc;
        end
      end
      if (contest && (gd || gc)) m_last = gc ? 1 : 0;
      if (gd) ms[0].full = 0;
      if (gc) ms[1].full = 0;
      if (acc_d) ms[0] = '{1'b1, disp_block_id, disp_block};
      if (acc_c) ms[1] = '{1'b1, cmt_block_id, cmt_block};
    end
  end

  typedef struct {
    logic [IDW-1:0] id;
    bit             fd;
    bit             fc;
  } rec_t;
  rec_t log_q[$];

  // Compare process: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    bit gd, gc;
    m_grants(gd, gc);
    check("disp_ready", disp_ready, !ms[0].full || gd);
    check("cmt_ready", cmt_ready, !ms[1].full || gc);
    check("out_valid", out_valid, mo_valid);
    check("fallback_count", fallback_count, m_cnt);
    if (mo_valid) begin
      check("block_id_out", block_id_out, mo_id);
      check("block_out", block_out, mo_blk);
      check("from_dispatch", from_dispatch, mo_fd);
      check("from_commit", from_commit, mo_fc);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b1)
      log_q.push_back('{block_id_out, from_dispatch, from_commit});
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_valid = 0; disp_block_id = '0; disp_block = '0;
    cmt_valid  = 0; cmt_block_id  = '0; cmt_block  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    out_ready = 1'b1;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    log_q.delete();
  endtask

  // Both sources push nd/nc distinct requests; out_ready held low for the first 'stall' cycles.
  task automatic stream(input int nd, input int nc, input logic [IDW-1:0] bd,
                        input logic [IDW-1:0] bc, input int stall, input bit check_alt);
    int sd = 0, sc = 0, n;
    bit hs_d, hs_c;
    for (int cy = 0; cy < 300 && log_q.size() < nd + nc; cy++) begin
      out_ready     = (cy >= stall);
      disp_valid    = (sd < nd);
      disp_block_id = IDW'(bd + sd);
      disp_block    = pay(IDW'(bd + sd), 0);
      cmt_valid     = (sc < nc);
      cmt_block_id  = IDW'(bc + sc);
      cmt_block     = pay(IDW'(bc + sc), 1);
      #1;
      hs_d = disp_valid && disp_ready;
      hs_c = cmt_valid && cmt_ready;
      if (stall > 2 && cy == stall - 1) begin
        check("stall disp_ready low", disp_ready, 0);
        check("stall cmt_ready low", cmt_ready, 0);
        check("stall holds first commit id", block_id_out, bc);
      end
      cyc();
      if (hs_d) sd++;
      if (hs_c) sc++;
    end
    idle_inputs();
    check("stream output count", log_q.size(), nd + nc);
    for (int i = 0; i < nd; i++) begin
      n = 0;
      foreach (log_q[k]) if (log_q[k].fd && log_q[k].id == IDW'(bd + i)) n++;
      check("dispatch id issued once", n, 1);
    end
    for (int i = 0; i < nc; i++) begin
      n = 0;
      foreach (log_q[k]) if (log_q[k].fc && log_q[k].id == IDW'(bc + i)) n++;
      check("commit id issued once", n, 1);
    end
    if (check_alt)
      foreach (log_q[k]) check("alternation commit flag", log_q[k].fc, (k % 2) == 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    #3;
    do_reset();

    // Reset state
    check("reset out_valid", out_valid, 0);
    check("reset block_id_out", block_id_out, 0);
    check("reset block_out", block_out, 0);
    check("reset flags", {from_dispatch, from_commit}, 0);
    check("reset count", fallback_count, 0);
    check("reset readies", {disp_ready, cmt_ready}, 2'b11);

    // Single dispatch request
    disp_valid = 1; disp_block_id = 8'h12; disp_block = pay(8'h12, 0);
    cyc();
    idle_inputs();
    cyc();
    check("single out_valid", out_valid, 1);
    check("single id", block_id_out, 8'h12);
    check("single payload", block_out, pay(8'h12, 0));
    check("single flags", {from_dispatch, from_commit}, 2'b10);
    cyc();
    check("single count", fallback_count, 1);
    check("single drained", out_valid, 0);

    // Simultaneous distinct ids: commit wins the first contest
    do_reset();
    disp_valid = 1; disp_block_id = 8'h05; disp_block = pay(8'h05, 0);
    cmt_valid  = 1; cmt_block_id  = 8'h09; cmt_block  = pay(8'h09, 1);
    cyc();
    idle_inputs();
    cyc();
    check("rr first id", block_id_out, 8'h09);
    check("rr first flags", {from_dispatch, from_commit}, 2'b01);
    cyc();
    check("rr second id", block_id_out, 8'h05);
    check("rr second flags", {from_dispatch, from_commit}, 2'b10);
    cyc();
    check("rr count", fallback_count, 2);

    // Same id from both sources: merged into one commit-payload entry
    do_reset();
    disp_valid = 1; disp_block_id = 8'h33; disp_block = pay(8'h33, 0);
    cmt_valid  = 1; cmt_block_id  = 8'h33; cmt_block  = pay(8'h33, 1);
    cyc();
    idle_inputs();
    cyc();
    check("merge id", block_id_out, 8'h33);
    check("merge payload", block_out, pay(8'h33, 1));
    check("merge flags", {from_dispatch, from_commit}, 2'b11);
    check("merge readies", {disp_ready, cmt_ready}, 2'b11);
    cyc();
    check("merge count", fallback_count, 1);
    check("merge drained", out_valid, 0);

    // Backpressure with both sources pushing
    do_reset();
    stream(3, 3, 8'h40, 8'hC0, 5, 0);

    // Sustained alternation; 20 issues saturate the 4-bit counter
    do_reset();
    stream(10, 10, 8'h10, 8'h90, 0, 1);
    repeat (2) cyc();
    check("alternation count saturated", fallback_count, CNT_MAX);

    // Counter saturation, then reset mid-stall
    do_reset();
    stream(18, 0, 8'h20, 8'hE0, 0, 0);
    repeat (2) cyc();
    check("saturated count", fallback_count, 4'hF);
    out_ready = 0;
    disp_valid = 1; disp_block_id = 8'h77; disp_block = pay(8'h77, 0);
    cyc();
    idle_inputs();
    repeat (2) cyc();
    check("stalled out_valid", out_valid, 1);
    check("stalled id", block_id_out, 8'h77);
    #2;
    rst = 1'b0;
    #1;
    check("mid-reset out_valid", out_valid, 0);
    check("mid-reset count", fallback_count, 0);
    check("mid-reset readies", {disp_ready, cmt_ready}, 2'b11);
    cyc();
    rst = 1'b1;
    out_ready = 1;
    repeat (2) cyc();
    check("post-reset idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
